gpio_serial_loader: RTL and testbench



---
 rtl/gpio_cfg_pkg.sv | 45 ++++
 rtl/gpio_serial_clkgen.sv | 34 +++
 rtl/gpio_serial_loader.sv | 148 ++++++++++++++
 tb/tb_gpio_serial_loader.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_cfg_pkg.sv
// Shared definitions for the GPIO configuration serial loader:
// default geometry, config-word bit layout and loader FSM states.
package gpio_cfg_pkg;

  localparam int unsigned CFG_WIDTH_DEF     = 13;
  localparam int unsigned NUM_PER_CHAIN_DEF = 19;

  // Bit positions inside one per-GPIO configuration word
  localparam int unsigned BIT_MGMT_ENA    = 0;
  localparam int unsigned BIT_OUTENB      = 1;
  localparam int unsigned BIT_HOLDOVER    = 2;
  localparam int unsigned BIT_INP_DIS     = 3;
  localparam int unsigned BIT_IB_MODE_SEL = 4;
  localparam int unsigned BIT_ANALOG_EN   = 5;
  localparam int unsigned BIT_ANALOG_SEL  = 6;
  localparam int unsigned BIT_ANALOG_POL  = 7;
  localparam int unsigned BIT_SLOW_SEL    = 8;
  localparam int unsigned BIT_VTRIP_SEL   = 9;
  localparam int unsigned BIT_DM_LSB      = 10;
  localparam int unsigned DM_WIDTH        = 3;

  typedef struct packed {
    logic [DM_WIDTH-1:0] dm;
    logic                vtrip_sel;
    logic                slow_sel;
    logic                analog_pol;
    logic                analog_sel;
    logic                analog_en;
    logic                ib_mode_sel;
    logic                inp_dis;
    logic                holdover;
    logic                outenb;
    logic                mgmt_ena;
  } gpio_cfg_word_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LOAD_SETTLE,
    ST_LOAD,
    ST_DONE
  } loader_state_e;

endpackage

// File: rtl/gpio_serial_clkgen.sv
// Half-period timer: ticks phase_end_c_o on the last system cycle of each
// CLK_DIV-cycle phase while enabled; idles at zero otherwise.
module gpio_serial_clkgen #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic phase_end_c_o
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign phase_end_c_o = en_i && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = '0;
    if (en_i && !phase_end_c_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gpio_serial_loader.sv
// Snapshots the packed GPIO configuration and shifts it into the two
// gpio_control_block chains in lockstep, then pulses the parallel load.
module gpio_serial_loader
  import gpio_cfg_pkg::*;
#(
  parameter int unsigned NUM_PER_CHAIN = NUM_PER_CHAIN_DEF,
  parameter int unsigned CFG_WIDTH     = CFG_WIDTH_DEF,
  parameter int unsigned CLK_DIV       = 1
) (
  input  logic                                 wb_clk_i,
  input  logic                                 wb_rstn_i,
  input  logic [2*NUM_PER_CHAIN*CFG_WIDTH-1:0] gpio_cfg,
  input  logic                                 xfer_start,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 serial_clock,
  output logic                                 serial_load,
  output logic                                 serial_data_1,
  output logic                                 serial_data_2
);

  localparam int unsigned TOTAL_W = 2 * NUM_PER_CHAIN * CFG_WIDTH;
  localparam int unsigned IDX_W   = $clog2(TOTAL_W);
  localparam int unsigned BIT_W   = $clog2(CFG_WIDTH);
  localparam int unsigned GPIO_W  = $clog2(NUM_PER_CHAIN);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(CFG_WIDTH - 1);
  localparam logic [GPIO_W-1:0] GPIO_LAST = GPIO_W'(NUM_PER_CHAIN - 1);

  loader_state_e      state_q, state_d;
  logic [TOTAL_W-1:0] snap_q, snap_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [GPIO_W-1:0]  gpio_q, gpio_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               sclk_q, sclk_d;
  logic               load_q, load_d;
  logic               sd1_q, sd1_d;
  logic               sd2_q, sd2_d;
  logic               phase_end_c;
  logic               shifting_c;
  int unsigned        bit_pos, idx1, idx2;

  // busy_q is high exactly in the timed states, so it gates the phase timer
  gpio_serial_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk           (wb_clk_i),
    .rst_n         (wb_rstn_i),
    .en_i          (busy_q),
    .phase_end_c_o (phase_end_c)
  );

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    bit_d   = bit_q;
    gpio_d  = gpio_q;

    unique case (state_q)
      ST_IDLE: begin
        if (xfer_start) begin
          snap_d  = gpio_cfg;
          bit_d   = '0;
          gpio_d  = '0;
          state_d = ST_SHIFT_LO;
        end
      end
      ST_SHIFT_LO: begin
        if (phase_end_c) state_d = ST_SHIFT_HI;
      end
      ST_SHIFT_HI: begin
        if (phase_end_c) begin
          state_d = ST_SHIFT_LO;
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
            if (gpio_q == GPIO_LAST) begin
              gpio_d  = '0;
              state_d = ST_LOAD_SETTLE;
            end else begin
              gpio_d = gpio_q + GPIO_W'(1);
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      ST_LOAD_SETTLE: begin
        if (phase_end_c) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (phase_end_c) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Chain 1 walks GPIO N-1..0, chain 2 walks GPIO N..2N-1, MSB first
    bit_pos    = CFG_WIDTH - 1 - 32'(bit_d);
    idx1       = CFG_WIDTH * (NUM_PER_CHAIN - 1 - 32'(gpio_d)) + bit_pos;
    idx2       = CFG_WIDTH * (NUM_PER_CHAIN + 32'(gpio_d)) + bit_pos;
    shifting_c = (state_d == ST_SHIFT_LO) || (state_d == ST_SHIFT_HI);

    busy_d = shifting_c || (state_d == ST_LOAD_SETTLE) || (state_d == ST_LOAD);
    done_d = (state_d == ST_DONE);
    sclk_d = (state_d == ST_SHIFT_HI);
    load_d = (state_d == ST_LOAD);
    sd1_d  = shifting_c && snap_d[IDX_W'(idx1)];
    sd2_d  = shifting_c && snap_d[IDX_W'(idx2)];
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state_q <= ST_IDLE;
      snap_q  <= '0;
      bit_q   <= '0;
      gpio_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      load_q  <= 1'b0;
      sd1_q   <= 1'b0;
      sd2_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      bit_q   <= bit_d;
      gpio_q  <= gpio_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sclk_q  <= sclk_d;
      load_q  <= load_d;
      sd1_q   <= sd1_d;
      sd2_q   <= sd2_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign serial_clock  = sclk_q;
  assign serial_load   = load_q;
  assign serial_data_1 = sd1_q;
  assign serial_data_2 = sd2_q;

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Directed bench for gpio_serial_loader: one DUT at CLK_DIV=1, one at CLK_DIV=3,
// each observed by a chain model sampling on the falling clock edge.
module tb_gpio_serial_loader;

  localparam int N   = 19;
  localparam int W   = 13;
  localparam int TOT = 2 * N * W;
  localparam int CH  = N * W;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start1, start3;
  logic [TOT-1:0] cfg;

  logic b1, dn1, sc1, ld1, da1, db1;
  logic b3, dn3, sc3, ld3, da3, db3;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  gpio_serial_loader #(.NUM_PER_CHAIN(N), .CFG_WIDTH(W), .CLK_DIV(1)) dut1 (
    .wb_clk_i(clk), .wb_rstn_i(rst_n), .gpio_cfg(cfg), .xfer_start(start1),
    .busy(b1), .done(dn1), .serial_clock(sc1), .serial_load(ld1),
    .serial_data_1(da1), .serial_data_2(db1)
  );

  gpio_serial_loader #(.NUM_PER_CHAIN(N), .CFG_WIDTH(W), .CLK_DIV(3)) dut3 (
    .wb_clk_i(clk), .wb_rstn_i(rst_n), .gpio_cfg(cfg), .xfer_start(start3),
    .busy(b3), .done(dn3), .serial_clock(sc3), .serial_load(ld3),
    .serial_data_1(da3), .serial_data_2(db3)
  );

  // Monitor for the CLK_DIV=1 instance
  int n_rise1 = 0, n_busy1 = 0, n_load1 = 0, n_done1 = 0, n_ovl1 = 0;
  logic sc1_p = 1'b0, first1 = 1'b1, fa1 = 1'b0, fb1 = 1'b0;
  logic [CH-1:0] sr1a = '0, sr1b = '0;

  always @(negedge clk) begin
    if (sc1 && !sc1_p) begin
      if (first1) begin fa1 = da1; fb1 = db1; first1 = 1'b0; end
      sr1a = {sr1a[CH-2:0], da1};
      sr1b = {sr1b[CH-2:0], db1};
      n_rise1++;
    end
    if (!b1) first1 = 1'b1;
    sc1_p = sc1;
    if (b1) n_busy1++;
    if (ld1) n_load1++;
    if (dn1) n_done1++;
    if (dn1 && b1) n_ovl1++;
  end

  // Monitor for the CLK_DIV=3 instance, including phase run lengths
  int n_rise3 = 0, n_busy3 = 0, n_load3 = 0, n_done3 = 0;
  int hi_run = 0, lo_run = 0, ld_run = 0;
  int hi_min = 1000, hi_max = 0, lo_min = 1000, lo_max = 0, ld_max = 0;
  logic sc3_p = 1'b0;
  logic [CH-1:0] sr3a = '0, sr3b = '0;

  always @(negedge clk) begin
    if (sc3 && !sc3_p) begin
      sr3a = {sr3a[CH-2:0], da3};
      sr3b = {sr3b[CH-2:0], db3};
      n_rise3++;
      if (lo_run < lo_min) lo_min = lo_run;
      if (lo_run > lo_max) lo_max = lo_run;
      lo_run = 0;
    end
    if (sc3) hi_run++;
    else if (hi_run != 0) begin
      if (hi_run < hi_min) hi_min = hi_run;
      if (hi_run > hi_max) hi_max = hi_run;
      hi_run = 0;
    end
    if (b3 && !sc3) lo_run++;
    if (!b3) lo_run = 0;
    if (ld3) begin ld_run++; if (ld_run > ld_max) ld_max = ld_run; end
    else ld_run = 0;
    sc3_p = sc3;
    if (b3) n_busy3++;
    if (ld3) n_load3++;
    if (dn3) n_done3++;
  end

  function automatic logic [TOT-1:0] cfg_const(input logic [W-1:0] w);
    logic [TOT-1:0] c;
    for (int i = 0; i < 2 * N; i++) c[W*i +: W] = w;
    return c;
  endfunction

  function automatic logic [TOT-1:0] cfg_index(input logic [W-1:0] x);
    logic [TOT-1:0] c;
    for (int i = 0; i < 2 * N; i++) c[W*i +: W] = W'(i) ^ x;
    return c;
  endfunction

  // Chain 1 slot k (bits W*k) ends up holding GPIO k
  function automatic logic [CH-1:0] exp_chain1(input logic [TOT-1:0] c);
    logic [CH-1:0] r;
    for (int k = 0; k < N; k++) r[W*k +: W] = c[W*k +: W];
    return r;
  endfunction

  // Chain 2: k-th word shifted in is GPIO N+k, ending at bits W*(N-1-k)
  function automatic logic [CH-1:0] exp_chain2(input logic [TOT-1:0] c);
    logic [CH-1:0] r;
    for (int k = 0; k < N; k++) r[W*(N-1-k) +: W] = c[W*(N+k) +: W];
    return r;
  endfunction

  // Starts a transfer on dut1 (call at a falling edge); returns cycles to done
  task automatic xfer1(input logic [TOT-1:0] c, input int chg_at,
                       input logic [TOT-1:0] c2, input int rs_at, output int lat);
    cfg = c;
    start1 = 1'b1;
    lat = -1;
    for (int i = 1; i <= 3000; i++) begin
      @(negedge clk);
      if (i == 1) start1 = 1'b0;
      if (i == chg_at) cfg = c2;
      if (i == rs_at) start1 = 1'b1;
      if (i == rs_at + 1) start1 = 1'b0;
      if (dn1) begin lat = i; break; end
    end
    start1 = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; cfg = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({b1, dn1, sc1, ld1, da1, db1} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_dut1: got %b expected 000000", {b1, dn1, sc1, ld1, da1, db1});
    end
    tests_run++;
    if ({b3, dn3, sc3, ld3, da3, db3} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_dut3: got %b expected 000000", {b3, dn3, sc3, ld3, da3, db3});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({b1, dn1, sc1, ld1, da1, db1} !== 6'b0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: got %b expected 000000", {b1, dn1, sc1, ld1, da1, db1});
    end
  endtask

  task automatic test_const_word;
    logic [TOT-1:0] c;
    int lat, rb, bb, lb, db, ob;
    c = cfg_const(13'h1803);
    rb = n_rise1; bb = n_busy1; lb = n_load1; db = n_done1; ob = n_ovl1;
    xfer1(c, -1, c, -1, lat);
    repeat (2) @(negedge clk);
    tests_run++;
    if (lat != 497) begin tests_failed++; $display("FAIL const_latency: got %0d expected 497", lat); end
    tests_run++;
    if (n_busy1 - bb != 496) begin tests_failed++; $display("FAIL const_busy_cycles: got %0d expected 496", n_busy1 - bb); end
    tests_run++;
    if (n_rise1 - rb != 247) begin tests_failed++; $display("FAIL const_sclk_rises: got %0d expected 247", n_rise1 - rb); end
    tests_run++;
    if (n_load1 - lb != 1) begin tests_failed++; $display("FAIL const_load_cycles: got %0d expected 1", n_load1 - lb); end
    tests_run++;
    if (n_done1 - db != 1) begin tests_failed++; $display("FAIL const_done_count: got %0d expected 1", n_done1 - db); end
    tests_run++;
    if (n_ovl1 - ob != 0) begin tests_failed++; $display("FAIL const_done_with_busy: got %0d expected 0", n_ovl1 - ob); end
    tests_run++;
    if (sr1a !== exp_chain1(c)) begin tests_failed++; $display("FAIL const_chain1: got %h expected %h", sr1a, exp_chain1(c)); end
    tests_run++;
    if (sr1b !== exp_chain2(c)) begin tests_failed++; $display("FAIL const_chain2: got %h expected %h", sr1b, exp_chain2(c)); end
  endtask

  task automatic test_index_words;
    logic [TOT-1:0] c;
    logic e1, e2;
    int lat;
    c = cfg_index(13'h0000);
    e1 = c[W*(N-1) + W-1];
    e2 = c[W*N + W-1];
    xfer1(c, -1, c, -1, lat);
    repeat (2) @(negedge clk);
    tests_run++;
    if (lat != 497) begin tests_failed++; $display("FAIL index_latency: got %0d expected 497", lat); end
    tests_run++;
    if (sr1a !== exp_chain1(c)) begin tests_failed++; $display("FAIL index_chain1: got %h expected %h", sr1a, exp_chain1(c)); end
    tests_run++;
    if (sr1b !== exp_chain2(c)) begin tests_failed++; $display("FAIL index_chain2: got %h expected %h", sr1b, exp_chain2(c)); end
    tests_run++;
    if (fa1 !== e1) begin tests_failed++; $display("FAIL index_first_bit1: got %b expected %b", fa1, e1); end
    tests_run++;
    if (fb1 !== e2) begin tests_failed++; $display("FAIL index_first_bit2: got %b expected %b", fb1, e2); end
    // Mixed pattern so chain order errors cannot hide behind equal words
    c = cfg_index(13'h1555);
    xfer1(c, -1, c, -1, lat);
    repeat (2) @(negedge clk);
    tests_run++;
    if (sr1a !== exp_chain1(c)) begin tests_failed++; $display("FAIL mixed_chain1: got %h expected %h", sr1a, exp_chain1(c)); end
    tests_run++;
    if (sr1b !== exp_chain2(c)) begin tests_failed++; $display("FAIL mixed_chain2: got %h expected %h", sr1b, exp_chain2(c)); end
  endtask

  task automatic test_clk_div3;
    logic [TOT-1:0] c;
    int lat, rb, bb, lb, db;
    c = cfg_index(13'h0A5A);
    rb = n_rise3; bb = n_busy3; lb = n_load3; db = n_done3;
    cfg = c;
    start3 = 1'b1;
    lat = -1;
    for (int i = 1; i <= 4000; i++) begin
      @(negedge clk);
      if (i == 1) start3 = 1'b0;
      if (dn3) begin lat = i; break; end
    end
    start3 = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (lat != 1489) begin tests_failed++; $display("FAIL div3_latency: got %0d expected 1489", lat); end
    tests_run++;
    if (n_busy3 - bb != 1488) begin tests_failed++; $display("FAIL div3_busy_cycles: got %0d expected 1488", n_busy3 - bb); end
    tests_run++;
    if (n_rise3 - rb != 247) begin tests_failed++; $display("FAIL div3_sclk_rises: got %0d expected 247", n_rise3 - rb); end
    tests_run++;
    if (hi_min != 3 || hi_max != 3) begin tests_failed++; $display("FAIL div3_high_phase: got min %0d max %0d expected 3", hi_min, hi_max); end
    tests_run++;
    if (lo_min != 3 || lo_max != 3) begin tests_failed++; $display("FAIL div3_low_phase: got min %0d max %0d expected 3", lo_min, lo_max); end
    tests_run++;
    if (n_load3 - lb != 3 || ld_max != 3) begin tests_failed++; $display("FAIL div3_load: got %0d cycles run %0d expected 3", n_load3 - lb, ld_max); end
    tests_run++;
    if (n_done3 - db != 1) begin tests_failed++; $display("FAIL div3_done_count: got %0d expected 1", n_done3 - db); end
    tests_run++;
    if (sr3a !== exp_chain1(c) || sr3b !== exp_chain2(c)) begin
      tests_failed++;
      $display("FAIL div3_chains: got %h / %h expected %h / %h", sr3a, sr3b, exp_chain1(c), exp_chain2(c));
    end
  endtask

  task automatic test_no_restart;
    logic [TOT-1:0] c;
    int lat, bb, db;
    c = cfg_index(13'h0F0F);
    bb = n_busy1; db = n_done1;
    xfer1(c, 50, cfg_const(13'h0403), 100, lat);
    repeat (4) @(negedge clk);
    tests_run++;
    if (lat != 497) begin tests_failed++; $display("FAIL norestart_latency: got %0d expected 497", lat); end
    tests_run++;
    if (n_done1 - db != 1 || b1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL norestart_done: got %0d dones busy=%b expected 1 dones busy=0", n_done1 - db, b1);
    end
    tests_run++;
    if (n_busy1 - bb != 496) begin tests_failed++; $display("FAIL norestart_busy: got %0d expected 496", n_busy1 - bb); end
    tests_run++;
    if (sr1a !== exp_chain1(c) || sr1b !== exp_chain2(c)) begin
      tests_failed++;
      $display("FAIL norestart_snapshot: got %h / %h expected %h / %h", sr1a, sr1b, exp_chain1(c), exp_chain2(c));
    end
  endtask

  task automatic test_reset_mid;
    logic [TOT-1:0] c;
    int lb, lat, bb;
    c = cfg_const(13'h1803);
    lb = n_load1;
    cfg = c;
    start1 = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (i == 1) start1 = 1'b0;
    end
    tests_run++;
    if (b1 !== 1'b1) begin tests_failed++; $display("FAIL midreset_busy_before: got %b expected 1", b1); end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({b1, dn1, sc1, ld1, da1, db1} !== 6'b0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got %b expected 000000", {b1, dn1, sc1, ld1, da1, db1});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (n_load1 - lb != 0 || b1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_no_load: got %0d load cycles busy=%b expected 0 busy=0", n_load1 - lb, b1);
    end
    bb = n_busy1;
    xfer1(c, -1, c, -1, lat);
    repeat (2) @(negedge clk);
    tests_run++;
    if (lat != 497 || n_busy1 - bb != 496) begin
      tests_failed++;
      $display("FAIL midreset_recover: got latency %0d busy %0d expected 497 496", lat, n_busy1 - bb);
    end
    tests_run++;
    if (sr1a !== exp_chain1(c) || sr1b !== exp_chain2(c)) begin
      tests_failed++;
      $display("FAIL midreset_chains: got %h / %h expected %h / %h", sr1a, sr1b, exp_chain1(c), exp_chain2(c));
    end
  endtask

  task automatic test_back_to_back;
    logic [TOT-1:0] c;
    int lat, lat2, db, bb;
    c = cfg_index(13'h1234);
    db = n_done1; bb = n_busy1;
    xfer1(c, -1, c, -1, lat);
    // Held across the DONE cycle (ignored) and the following IDLE cycle (accepted)
    start1 = 1'b1;
    @(negedge clk);
    tests_run++;
    if (b1 !== 1'b0) begin tests_failed++; $display("FAIL b2b_done_start_ignored: got busy %b expected 0", b1); end
    @(negedge clk);
    start1 = 1'b0;
    tests_run++;
    if (b1 !== 1'b1) begin tests_failed++; $display("FAIL b2b_busy_rise: got %b expected 1", b1); end
    lat2 = -1;
    for (int i = 1; i <= 3000; i++) begin
      @(negedge clk);
      if (dn1) begin lat2 = i; break; end
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if (lat != 497 || lat2 != 496) begin
      tests_failed++;
      $display("FAIL b2b_latency: got %0d %0d expected 497 496", lat, lat2);
    end
    tests_run++;
    if (n_done1 - db != 2 || n_busy1 - bb != 992) begin
      tests_failed++;
      $display("FAIL b2b_counts: got %0d dones %0d busy expected 2 992", n_done1 - db, n_busy1 - bb);
    end
    tests_run++;
    if (sr1a !== exp_chain1(c) || sr1b !== exp_chain2(c)) begin
      tests_failed++;
      $display("FAIL b2b_chains: got %h / %h expected %h / %h", sr1a, sr1b, exp_chain1(c), exp_chain2(c));
    end
  endtask

  initial begin
    test_reset();
    test_const_word();
    test_index_words();
    test_clk_div3();
    test_no_restart();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
